// File: rtl/wfr_sample_packer_if.sv
// Sample-in / packed-word-out bundle between a sample source and wfr_sample_packer.
// The master drives samples and control; the slave (the packer) returns packed words.
interface wfr_sample_packer_if #(
  parameter int SAMPLE_WIDTH    = 32,
  parameter int LANES           = 4,
  parameter int DECIM_WIDTH     = 16,
  parameter int TIMESTAMP_WIDTH = 64
);
  localparam int DATA_WIDTH = SAMPLE_WIDTH * LANES;

  logic                       enable;
  logic [DECIM_WIDTH-1:0]     decimFactor;
  logic [SAMPLE_WIDTH-1:0]    sampleIn;
  logic                       sampleValid;
  logic [7:0]                 triggersIn;
  logic [TIMESTAMP_WIDTH-1:0] timestampIn;
  logic [DATA_WIDTH-1:0]      dataOut;
  logic                       validOut;
  logic [7:0]                 triggersOut;
  logic [TIMESTAMP_WIDTH-1:0] timestampOut;

  modport master (
    output enable, decimFactor, sampleIn, sampleValid, triggersIn, timestampIn,
    input  dataOut, validOut, triggersOut, timestampOut
  );

  modport slave (
    input  enable, decimFactor, sampleIn, sampleValid, triggersIn, timestampIn,
    output dataOut, validOut, triggersOut, timestampOut
  );
endinterface

// File: rtl/wfr_sample_packer.sv
// Decimates a narrow sample stream and packs LANES accepted samples into one wide word,
// with a lane-0 timestamp and the OR of triggers seen over the word's window.

module wfr_sample_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  logic [W-1:0] lane_d, lane_q;

  always_comb begin
    lane_d = lane_q;
    if (clr)     lane_d = '0;
    else if (we) lane_d = din;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) lane_q <= '0;
    else       lane_q <= lane_d;
  end

  assign q = lane_q;
endmodule

module wfr_sample_packer #(
  parameter int SAMPLE_WIDTH    = 32,
  parameter int LANES           = 4,
  parameter int DECIM_WIDTH     = 16,
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rstN,
  wfr_sample_packer_if.slave bus
);
  localparam int DATA_WIDTH = SAMPLE_WIDTH * LANES;
  localparam int LANE_W     = $clog2(LANES);

  logic [DECIM_WIDTH-1:0]     decim_cnt_q, decim_cnt_d;
  logic [DECIM_WIDTH-1:0]     decim_factor_q, decim_factor_d;
  logic [LANE_W-1:0]          lane_cnt_q, lane_cnt_d;
  logic [7:0]                 trig_acc_q, trig_acc_d;
  logic [7:0]                 trig_out_q, trig_out_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_cap_q, ts_cap_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_out_q, ts_out_d;
  logic [DATA_WIDTH-1:0]      data_out_q, data_out_d;
  logic                       valid_q, valid_d;

  logic                                accept;
  logic                                last_lane;
  logic [LANES-2:0]                    lane_we;
  logic [LANES-2:0][SAMPLE_WIDTH-1:0]  lane_q;

  assign accept    = bus.enable && bus.sampleValid && (decim_cnt_q == '0);
  assign last_lane = (lane_cnt_q == LANE_W'(LANES - 1));

  // The top lane is never stored: it goes straight from sampleIn into dataOut.
  for (genvar i = 0; i < LANES - 1; i++) begin : g_lane
    assign lane_we[i] = accept && (lane_cnt_q == LANE_W'(i));

    wfr_sample_lane #(.W(SAMPLE_WIDTH)) u_lane (
      .clk  (clk),
      .rstN (rstN),
      .clr  (!bus.enable),
      .we   (lane_we[i]),
      .din  (bus.sampleIn),
      .q    (lane_q[i])
    );
  end

  always_comb begin
    decim_cnt_d    = decim_cnt_q;
    decim_factor_d = decim_factor_q;
    lane_cnt_d     = lane_cnt_q;
    trig_acc_d     = trig_acc_q;
    trig_out_d     = trig_out_q;
    ts_cap_d       = ts_cap_q;
    ts_out_d       = ts_out_q;
    data_out_d     = data_out_q;
    valid_d        = 1'b0;

    if (!bus.enable) begin
      // Idle: re-arm from scratch and track the requested ratio.
      decim_factor_d = bus.decimFactor;
      decim_cnt_d    = '0;
      lane_cnt_d     = '0;
      trig_acc_d     = '0;
    end else begin
      trig_acc_d = trig_acc_q | bus.triggersIn;
      if (bus.sampleValid)
        decim_cnt_d = (decim_cnt_q == decim_factor_q) ? '0 : decim_cnt_q + 1'b1;
      if (accept) begin
        if (lane_cnt_q == '0) ts_cap_d = bus.timestampIn;
        if (last_lane) begin
          lane_cnt_d = '0;
          valid_d    = 1'b1;
          data_out_d = {bus.sampleIn, lane_q};
          trig_out_d = trig_acc_q | bus.triggersIn;
          trig_acc_d = '0;
          ts_out_d   = ts_cap_q;
        end else begin
          lane_cnt_d = lane_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      decim_cnt_q    <= '0;
      decim_factor_q <= '0;
      lane_cnt_q     <= '0;
      trig_acc_q     <= '0;
      trig_out_q     <= '0;
      ts_cap_q       <= '0;
      ts_out_q       <= '0;
      data_out_q     <= '0;
      valid_q        <= 1'b0;
    end else begin
      decim_cnt_q    <= decim_cnt_d;
      decim_factor_q <= decim_factor_d;
      lane_cnt_q     <= lane_cnt_d;
      trig_acc_q     <= trig_acc_d;
      trig_out_q     <= trig_out_d;
      ts_cap_q       <= ts_cap_d;
      ts_out_q       <= ts_out_d;
      data_out_q     <= data_out_d;
      valid_q        <= valid_d;
    end
  end

  assign bus.dataOut      = data_out_q;
  assign bus.validOut     = valid_q;
  assign bus.triggersOut  = trig_out_q;
  assign bus.timestampOut = ts_out_q;
endmodule

// File: tb/tb_wfr_sample_packer.sv
// Bench for wfr_sample_packer: directed scenarios plus random sparse traffic, all checked
// against a queue-based model of accepted samples.
module tb_wfr_sample_packer;
  localparam int SW  = 32;
  localparam int L   = 4;
  localparam int DCW = 16;
  localparam int TW  = 64;
  localparam int DW  = SW * L;

  logic clk;
  logic rstN;
  int   n_checks = 0;
  int   n_fail   = 0;

  wfr_sample_packer_if #(.SAMPLE_WIDTH(SW), .LANES(L), .DECIM_WIDTH(DCW), .TIMESTAMP_WIDTH(TW)) bus ();

  wfr_sample_packer #(.SAMPLE_WIDTH(SW), .LANES(L), .DECIM_WIDTH(DCW), .TIMESTAMP_WIDTH(TW)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a valid sample is kept when its index since enable is a multiple of (ratio+1).
  logic [TW-1:0]  tsc;
  longint         m_df;
  longint         m_vcount;
  longint         m_acc;
  logic [SW-1:0]  m_buf[$];
  logic [TW-1:0]  m_ts0;
  logic [7:0]     m_trig;
  logic           e_valid;
  logic [DW-1:0]  e_data;
  logic [7:0]     e_trig;
  logic [TW-1:0]  e_ts;

  function automatic void model_reset();
    m_df = 0; m_vcount = 0; m_buf.delete(); m_trig = '0; m_ts0 = '0;
    e_valid = 1'b0; e_data = '0; e_trig = '0; e_ts = '0;
  endfunction

  function automatic void model(input logic en, input logic sv, input logic [SW-1:0] s,
                                input logic [7:0] tr, input logic [TW-1:0] ts,
                                input logic [DCW-1:0] df);
    e_valid = 1'b0;
    if (!en) begin
      m_df = longint'(df); m_vcount = 0; m_buf.delete(); m_trig = '0;
    end else begin
      m_trig = m_trig | tr;
      if (sv) begin
        if (m_vcount % (m_df + 1) == 0) begin
          m_acc++;
          if (m_buf.size() == 0) m_ts0 = ts;
          m_buf.push_back(s);
          if (m_buf.size() == L) begin
            for (int i = 0; i < L; i++) e_data[i*SW +: SW] = m_buf[i];
            e_valid = 1'b1; e_trig = m_trig; e_ts = m_ts0;
            m_trig = '0; m_buf.delete();
          end
        end
        m_vcount++;
      end
    end
  endfunction

  task automatic step(input logic en, input logic sv, input logic [SW-1:0] s,
                      input logic [7:0] tr, input logic [DCW-1:0] df);
    bus.enable = en; bus.sampleValid = sv; bus.sampleIn = s;
    bus.triggersIn = tr; bus.decimFactor = df; bus.timestampIn = tsc;
    model(en, sv, s, tr, tsc, df);
    @(posedge clk); #1;
    tsc = tsc + 1;
  endtask

  task automatic idle(input int n, input logic [DCW-1:0] df);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, df);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.enable = 1'b1; bus.sampleValid = 1'b1; bus.sampleIn = 32'hDEAD_BEEF;
    bus.triggersIn = 8'hFF; bus.decimFactor = '0; bus.timestampIn = tsc;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0",
                         {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut});
    end
    bus.enable = 1'b0; bus.sampleValid = 1'b0;
    #3 rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int npulse = 0;
    int pcyc[$];
    logic [TW-1:0] ts_at[$];
    logic [TW-1:0] ts_seen[$];
    logic [DW-1:0] last_data = '0;
    idle(2, '0);
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) ts_at.push_back(tsc);
      step(1'b1, 1'b1, SW'(k + 1), '0, '0);
      n_checks++;
      if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== {e_valid, e_data, e_trig, e_ts}) begin
        n_fail++; $display("FAIL b2b_model k=%0d: got %h required %h", k,
          {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut}, {e_valid, e_data, e_trig, e_ts});
      end
      if (bus.validOut) begin
        npulse++; pcyc.push_back(k); ts_seen.push_back(bus.timestampOut); last_data = bus.dataOut;
      end
    end
    n_checks++;
    if (npulse != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d required 3", npulse); end
    for (int i = 1; i < pcyc.size(); i++) begin
      n_checks++;
      if (pcyc[i] - pcyc[i-1] != 4) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d required 4", pcyc[i] - pcyc[i-1]);
      end
    end
    n_checks++;
    if (last_data !== {32'd12, 32'd11, 32'd10, 32'd9}) begin
      n_fail++; $display("FAIL b2b_last_word: got %h required %h", last_data, {32'd12, 32'd11, 32'd10, 32'd9});
    end
    for (int i = 0; i < ts_seen.size() && i < 3; i++) begin
      n_checks++;
      if (ts_seen[i] !== ts_at[i]) begin
        n_fail++; $display("FAIL b2b_timestamp%0d: got %h required %h", i, ts_seen[i], ts_at[i]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int npulse = 0;
    logic [DW-1:0] word = '0;
    logic [DW-1:0] want;
    want = {32'h44, 32'h33, 32'h22, 32'h11};
    idle(2, '0);
    step(1'b1, 1'b1, 32'hAAAA_0001, '0, '0);
    step(1'b1, 1'b1, 32'hAAAA_0002, '0, '0);
    #2 rstN = 1'b0;
    #1;
    n_checks++;
    if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== '0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h required 0",
                         {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut});
    end
    model_reset();
    @(posedge clk); #1;
    rstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, SW'((k + 1) * 'h11), '0, '0);
      n_checks++;
      if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== {e_valid, e_data, e_trig, e_ts}) begin
        n_fail++; $display("FAIL midrst_model k=%0d: got %h required %h", k,
          {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut}, {e_valid, e_data, e_trig, e_ts});
      end
      if (bus.validOut) begin npulse++; word = bus.dataOut; end
    end
    n_checks++;
    if (npulse != 1 || word !== want) begin
      n_fail++; $display("FAIL midrst_word: got %0d pulses word %h required 1 pulse word %h", npulse, word, want);
    end
  endtask

  task automatic test_decimation();
    logic [DW-1:0] words[$];
    logic [DW-1:0] w0, w1, w2;
    w0 = {32'd9, 32'd6, 32'd3, 32'd0};
    w1 = {32'd21, 32'd18, 32'd15, 32'd12};
    w2 = {32'd103, 32'd102, 32'd101, 32'd100};
    idle(2, 16'd2);
    for (int k = 0; k < 24; k++) begin
      // ratio change while enabled must be ignored
      step(1'b1, 1'b1, SW'(k), '0, (k < 12) ? 16'd2 : 16'd0);
      n_checks++;
      if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== {e_valid, e_data, e_trig, e_ts}) begin
        n_fail++; $display("FAIL decim_model k=%0d: got %h required %h", k,
          {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut}, {e_valid, e_data, e_trig, e_ts});
      end
      if (bus.validOut) words.push_back(bus.dataOut);
    end
    n_checks++;
    if (words.size() != 2) begin
      n_fail++; $display("FAIL decim_count: got %0d required 2", words.size());
    end else begin
      n_checks++;
      if (words[0] !== w0 || words[1] !== w1) begin
        n_fail++; $display("FAIL decim_words: got %h %h required %h %h", words[0], words[1], w0, w1);
      end
    end
    idle(2, 16'd0);
    words.delete();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, SW'(100 + k), '0, 16'd0);
      if (bus.validOut) words.push_back(bus.dataOut);
    end
    n_checks++;
    if (words.size() != 1 || words[0] !== w2) begin
      n_fail++; $display("FAIL decim_retoggle: got %0d words first %h required 1 word %h",
                         words.size(), (words.size() > 0) ? words[0] : '0, w2);
    end
  endtask

  task automatic test_triggers();
    logic [7:0] trs[$];
    idle(2, '0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, $urandom, (k == 5) ? 8'h04 : 8'h00, '0);
      n_checks++;
      if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== {e_valid, e_data, e_trig, e_ts}) begin
        n_fail++; $display("FAIL trig_model k=%0d: got %h required %h", k,
          {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut}, {e_valid, e_data, e_trig, e_ts});
      end
      if (bus.validOut) trs.push_back(bus.triggersOut);
    end
    n_checks++;
    if (trs.size() != 3 || trs[0] !== 8'h00 || trs[1] !== 8'h04 || trs[2] !== 8'h00) begin
      n_fail++; $display("FAIL trig_words: got %0d words %h required 3 words 00 04 00", trs.size(),
                         (trs.size() == 3) ? {trs[0], trs[1], trs[2]} : 24'h0);
    end
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] held;
    int npulse = 0;
    logic [DW-1:0] word = '0;
    logic [DW-1:0] want;
    want = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    idle(2, '0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, SW'(k + 1), '0, '0);
    held = bus.dataOut;
    step(1'b0, 1'b1, SW'(4), '0, '0);
    n_checks++;
    if (bus.validOut !== 1'b0 || bus.dataOut !== held) begin
      n_fail++; $display("FAIL endrop_no_word: got v=%0b d=%h required v=0 d=%h", bus.validOut, bus.dataOut, held);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, SW'('hA1 + k), '0, '0);
      n_checks++;
      if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== {e_valid, e_data, e_trig, e_ts}) begin
        n_fail++; $display("FAIL endrop_model k=%0d: got %h required %h", k,
          {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut}, {e_valid, e_data, e_trig, e_ts});
      end
      if (bus.validOut) begin npulse++; word = bus.dataOut; end
    end
    n_checks++;
    if (npulse != 1 || word !== want) begin
      n_fail++; $display("FAIL endrop_word: got %0d pulses word %h required 1 pulse word %h", npulse, word, want);
    end
  endtask

  task automatic test_sparse();
    int npulse = 0;
    logic sv;
    logic [7:0] tr;
    idle(2, 16'd1);
    m_acc = 0;
    for (int k = 0; k < 400; k++) begin
      sv = ($urandom_range(0, 99) < 30);
      tr = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00;
      step(1'b1, sv, $urandom, tr, 16'd1);
      n_checks++;
      if ({bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut} !== {e_valid, e_data, e_trig, e_ts}) begin
        n_fail++; $display("FAIL sparse_model k=%0d: got %h required %h", k,
          {bus.validOut, bus.dataOut, bus.triggersOut, bus.timestampOut}, {e_valid, e_data, e_trig, e_ts});
      end
      if (bus.validOut) npulse++;
    end
    n_checks++;
    if (longint'(npulse) != m_acc / L) begin
      n_fail++; $display("FAIL sparse_count: got %0d required %0d", npulse, m_acc / L);
    end
  endtask

  initial begin
    tsc = {$urandom, $urandom};
    m_acc = 0;
    test_reset();
    test_back_to_back();
    test_reset_mid_word();
    test_decimation();
    test_triggers();
    test_enable_drop();
    test_sparse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wfr_sample_packer.md
# wfr_sample_packer

Upstream feeder for the generic waveform recorder, running in the recorder's data clock domain. Accepts a stream of narrow samples with a valid strobe and optionally decimates them. Packs groups of LANES accepted samples into one DATA_WIDTH word. Emits that word with a one-cycle valid pulse, plus a per-word timestamp and trigger vector that drive the recorder's data, valid, timestamp and triggers inputs.

## Interface
Parameters:
- SAMPLE_WIDTH, 32: width of one input sample.
- LANES, 4: samples packed per output word; DATA_WIDTH = SAMPLE_WIDTH*LANES (128 by default).
- DECIM_WIDTH, 16: width of decimation control.
- TIMESTAMP_WIDTH, 64: timestamp width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  data clock, all logic on rising edge.
- rstN  in  1  asynchronous active-low reset.
- enable  in  1  level; packing runs while high.
- decimFactor  in  DECIM_WIDTH  keep 1 of every decimFactor+1 valid samples.
- sampleIn  in  SAMPLE_WIDTH  input sample.
- sampleValid  in  1  sampleIn qualifier.
- triggersIn  in  8  trigger levels/pulses.
- timestampIn  in  TIMESTAMP_WIDTH  free-running timestamp.
- dataOut  out  DATA_WIDTH  packed word, lane 0 in bits [SAMPLE_WIDTH-1:0].
- validOut  out  1  one-cycle pulse per completed word.
- triggersOut  out  8  OR of triggersIn over the word's accumulation window.
- timestampOut  out  TIMESTAMP_WIDTH  timestampIn at the word's lane-0 sample.

## Operation
- **Reset (rstN low, asynchronous):**
  - All outputs go to 0.
  - Lane counter, decimation counter, partial word, trigger accumulator and captured decimFactor all clear.
- **Decimation:**
  - decimCnt counts valid samples while enabled.
  - A sample is accepted when decimCnt == 0 and sampleValid is high.
  - On every valid sample, decimCnt wraps to 0 after reaching decimFactorQ; otherwise it increments.
  - decimFactor = 0 means every sample is accepted.
  - decimFactorQ is captured from decimFactor on every cycle that enable is low. Changes while enabled are ignored.
- **Packing:**
  - An accepted sample is written into lane laneCnt, and laneCnt increments.
  - When lane LANES-1 is written:
    - the full word (including that sample) goes to dataOut;
    - validOut is pulsed;
    - laneCnt returns to 0.
- **Timestamp:** timestampIn is captured into an internal register on each lane-0 acceptance. It is transferred to timestampOut together with dataOut.
- **Triggers:**
  - triggerAcc ORs triggersIn on every enabled cycle.
  - When a word completes, triggersOut <= triggerAcc | triggersIn, and triggerAcc clears in the same cycle.
- **Output hold:** dataOut, timestampOut and triggersOut hold their values between validOut pulses.
- **enable low:**
  - laneCnt, decimCnt and triggerAcc clear synchronously, and the partial word is discarded.
  - sampleValid is ignored.
  - Outputs hold their last values; validOut = 0.
- **Simultaneous events:**
  - If enable falls in the same cycle as a lane LANES-1 acceptance would occur, the sample is not accepted and no validOut is produced. enable is sampled, not edge-detected.
  - If enable rises, the first valid sample in that cycle is accepted into lane 0 with decimCnt = 0.
- **Width rules:**
  - decimCnt is DECIM_WIDTH wide and compared for equality, so there is no overflow (max ratio 2^DECIM_WIDTH).
  - laneCnt is $clog2(LANES) wide (LANES ≥ 2).

## Timing
- validOut is asserted in the cycle after the clock edge at which the LANES-th sample is accepted. dataOut, timestampOut and triggersOut update on that same edge (latency 1).
- Maximum throughput: sampleValid every cycle with decimFactor = 0 gives one validOut every LANES cycles. No backpressure exists; downstream must accept every pulse.
- validOut is never high for two consecutive cycles when LANES ≥ 2.
- Asynchronous reset assertion forces outputs to 0 immediately. Deassertion is synchronized externally; the first accepted sample after release goes to lane 0.

## Test plan
- **Reset mid-word:** rstN low while 2 of 4 lanes are filled, then 4 samples 0x11..0x44 → one validOut, dataOut = 0x00000044_00000033_00000022_00000011, no stale lanes.
- **Back-to-back packing:** decimFactor = 0, valid every cycle, samples 1..12 → exactly 3 validOut pulses, 4 cycles apart; last dataOut = {12,11,10,9}; timestampOut equals timestampIn at samples 1, 5, 9.
- **Decimation:** decimFactor = 2, samples 0..23 → accepted 0,3,6,...,21; 2 words, {9,6,3,0} and {21,18,15,12}. Changing decimFactor while enabled has no effect until after enable toggles low.
- **Trigger accumulation:** a 1-cycle pulse triggersIn = 0x04 during lane 1 of word 2 → triggersOut = 0x00 for word 1, 0x04 for word 2, 0x00 for word 3.
- **Enable drop:** enable falls on the cycle of the 4th sample → no validOut. Re-enable and feed 4 samples → one word containing only the new samples.
- **Sparse valid:** sampleValid at random 30% density, decimFactor = 1 → the validOut count equals floor(accepted/4), and word contents match a reference model.
